puf_reader: RTL and testbench
=============================

PUF_READER -- requirements
Module: puf_reader

Interface
REQ-001 SHALL have parameter N_OSC, default 16, meaning the number of ring-oscillator inputs.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the edge-counter width.
REQ-003 SHALL have parameter GATE_CYCLES, default 4096, meaning the measurement window length in ICE_CLK cycles.
REQ-004 SHALL have port ICE_CLK  input  1  the single system clock.
REQ-005 SHALL have port ICE_RST_N  input  1  the reset; asynchronous, active-low.
REQ-006 SHALL have port osc_in  input  N_OSC  the free-running ring-oscillator outputs, asynchronous to ICE_CLK.
REQ-007 SHALL have port start  input  1  a request pulse, sampled only while idle.
REQ-008 SHALL have port chal_a  input  $clog2(N_OSC)  the first oscillator index of the challenge pair.
REQ-009 SHALL have port chal_b  input  $clog2(N_OSC)  the second oscillator index of the challenge pair.
REQ-010 SHALL have port busy  output  1  high from start acceptance until resp_valid.
REQ-011 SHALL have port resp_valid  output  1  a one-cycle result strobe.
REQ-012 SHALL have port resp_bit  output  1  the response: 1 iff cnt_a > cnt_b.
REQ-013 SHALL have port resp_err  output  1  flags an invalid challenge or a saturated count.
REQ-014 SHALL have ports cnt_a and cnt_b  output  CNT_W each  the raw edge counts.

Function
REQ-015 SHALL latch chal_a/chal_b on the cycle start is accepted; challenge input changes while busy SHALL be ignored.
REQ-016 SHALL ignore start while busy (no queueing).
REQ-017 SHALL pass each selected oscillator through a 2-flop synchronizer, then a rising-edge detector; one detected edge SHALL increment its counter by exactly 1.
REQ-018 SHALL implement FSM states IDLE, SETTLE, COUNT, COMPARE, DONE.
REQ-019 SHALL transition IDLE->SETTLE on start when chal_a != chal_b; SETTLE SHALL last 4 cycles and clear both counters, so synchronizers flush stale values from the previously selected oscillator.
REQ-020 SHALL count edges in COUNT for exactly GATE_CYCLES cycles, using a gate counter that reloads on entry.
REQ-021 SHALL transition COUNT->COMPARE after the final gate cycle; edges detected on that final cycle SHALL be counted.
REQ-022 SHALL compute the following in COMPARE: resp_bit = (cnt_a > cnt_b), unsigned; on a tie, resp_bit = 0.
REQ-023 SHALL assert resp_valid for exactly one cycle in DONE, then return to IDLE; busy SHALL drop in that same cycle.
REQ-024 SHALL saturate the edge counters at all-ones (no wrap); resp_err SHALL be 1 if either counter saturated.
REQ-025 SHALL, when start arrives with chal_a == chal_b, go IDLE->DONE directly, with resp_err=1, resp_bit=0, and cnt_a=cnt_b=0.
REQ-026 SHALL hold resp_bit, resp_err, cnt_a and cnt_b stable from resp_valid until the next start is accepted.
REQ-027 SHALL support oscillator frequencies below ICE_CLK/4; behaviour above that limit SHALL be undercounting only, never X or lockup.
REQ-028 SHALL accept a start pulse in the same cycle resp_valid drops, i.e. the cycle after DONE.

Reset
REQ-029 SHALL, on ICE_RST_N low, asynchronously force: state IDLE; busy=0; resp_valid=0; resp_bit=0; resp_err=0; cnt_a=cnt_b=0; synchronizer flops=0.
REQ-030 SHALL, on reset asserted mid-measurement, abort with no resp_valid; after release the block SHALL be idle and accept a new start.

Structure
REQ-031 SHALL place the FSM state enum and the SETTLE length constant (4) in shared package puf_pkg.
REQ-032 SHALL instantiate sub-module puf_edge_counter (synchronizer, edge detect, saturating counter, clear input) twice, once for cnt_a and once for cnt_b.
REQ-033 SHALL use a plain N_OSC:1 multiplexer, indexed by the latched challenge, for oscillator selection.

Verification
REQ-034 SHALL verify: osc[3] period 8 clk, osc[5] period 10 clk, GATE_CYCLES=4096, chal_a=3, chal_b=5 -> cnt_a=512±1, cnt_b=409±1, resp_bit=1, resp_err=0.
REQ-035 SHALL verify: swap the challenge (chal_a=5, chal_b=3), same stimulus -> resp_bit=0.
REQ-036 SHALL verify: chal_a=chal_b=7 -> resp_valid 1 cycle after start, resp_err=1, resp_bit=0, counts 0.
REQ-037 SHALL verify: CNT_W=8, osc period 4 clk, GATE_CYCLES=4096 -> cnt_a=255, resp_err=1.
REQ-038 SHALL verify: ICE_RST_N pulsed low at gate cycle 2000 -> no resp_valid, all outputs 0; a subsequent start completes normally.
REQ-039 SHALL verify: second start while busy -> ignored; exactly one resp_valid per accepted start.

Source files
------------

// File: rtl/puf_pkg.sv
// ----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the ring-oscillator PUF reader.
//   state_t        : measurement FSM states used by puf_reader
//   SETTLE_CYCLES  : cycles spent in SETTLE so the synchronizers flush the
//                    previously selected oscillator before counting begins
// ----------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned SETTLE_CYCLES = 4;

endpackage

// File: rtl/puf_edge_counter.sv
// ----------------------------------------------------------------------------
// puf_edge_counter
// Counts rising edges of one asynchronous ring-oscillator signal.
// The oscillator passes through a 2-flop synchronizer, then a rising-edge
// detector; every detected edge adds exactly one to a saturating counter.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (clears synchronizer and count)
//   osc        : oscillator signal, asynchronous to clk
//   clear      : synchronous clear of the count (synchronizer keeps running)
//   enable     : count detected edges only while high
//   count      : current edge count, sticks at all-ones
//   saturated  : high when count is all-ones
// ----------------------------------------------------------------------------
module puf_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             saturated
);

    logic [1:0] sync;
    logic       prev;
    logic       rise;

    // Synchronizer and edge-detect history run every cycle, including while
    // the counter is cleared, so a newly selected oscillator is flushed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], osc};
            prev <= sync[1];
        end
    end

    assign rise      = sync[1] & ~prev;
    assign saturated = &count;

    // Saturating counter: once all-ones it holds so the error is visible
    // instead of wrapping to a small, plausible-looking value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && rise && !saturated) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/puf_reader.sv
// ----------------------------------------------------------------------------
// puf_reader
// Ring-oscillator PUF response reader. On start, a challenge pair of
// oscillator indices is latched; both oscillators are counted over a fixed
// gate window and the response bit reports whether the first ran faster.
//
// Ports
//   ICE_CLK     : system clock
//   ICE_RST_N   : asynchronous active-low reset
//   osc_in      : free-running ring-oscillator outputs (asynchronous)
//   start       : request pulse, only looked at while idle
//   chal_a/b    : challenge oscillator indices
//   busy        : measurement in progress (drops when resp_valid rises)
//   resp_valid  : one-cycle result strobe
//   resp_bit    : 1 iff cnt_a > cnt_b (ties give 0)
//   resp_err    : invalid challenge (a == b) or a saturated counter
//   cnt_a/cnt_b : raw edge counts, held until the next accepted start
// ----------------------------------------------------------------------------
module puf_reader
    import puf_pkg::*;
#(
    parameter int N_OSC       = 16,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 4096
) (
    input  logic                     ICE_CLK,
    input  logic                     ICE_RST_N,
    input  logic [N_OSC-1:0]         osc_in,
    input  logic                     start,
    input  logic [$clog2(N_OSC)-1:0] chal_a,
    input  logic [$clog2(N_OSC)-1:0] chal_b,
    output logic                     busy,
    output logic                     resp_valid,
    output logic                     resp_bit,
    output logic                     resp_err,
    output logic [CNT_W-1:0]         cnt_a,
    output logic [CNT_W-1:0]         cnt_b
);

    localparam int IDX_W    = $clog2(N_OSC);
    localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);

    localparam logic [GATE_W-1:0]   GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    chal_a_q;
    logic [IDX_W-1:0]    chal_b_q;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GATE_W-1:0]   gate_cnt;
    logic                chal_invalid;
    logic                settle_done;
    logic                gate_done;
    logic                clear_cnt;
    logic                count_en;
    logic                sel_a;
    logic                sel_b;
    logic                sat_a;
    logic                sat_b;

    assign chal_invalid = (chal_a == chal_b);
    assign settle_done  = (settle_cnt == SETTLE_LAST);
    assign gate_done    = (gate_cnt == '0);

    // Oscillator selection uses the latched challenge, so challenge inputs
    // may change freely while a measurement is running.
    assign sel_a = osc_in[chal_a_q];
    assign sel_b = osc_in[chal_b_q];

    // State register
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. Counters are also cleared on the
    // accepting cycle so an invalid challenge reports zero counts in DONE.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        resp_valid = 1'b0;
        clear_cnt  = 1'b0;
        count_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_cnt  = 1'b1;
                    next_state = chal_invalid ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                busy      = 1'b1;
                clear_cnt = 1'b1;
                if (settle_done) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                busy     = 1'b1;
                count_en = 1'b1;
                if (gate_done) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: challenge latch, settle/gate timers and response registers.
    // The gate counter is loaded on the last SETTLE cycle and COUNT lasts
    // until it reaches zero, giving exactly GATE_CYCLES counting cycles.
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            chal_a_q   <= '0;
            chal_b_q   <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            resp_bit   <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        chal_a_q   <= chal_a;
                        chal_b_q   <= chal_b;
                        settle_cnt <= '0;
                        resp_bit   <= 1'b0;
                        resp_err   <= chal_invalid;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_done) begin
                        gate_cnt <= GATE_LOAD;
                    end
                end
                COUNT: begin
                    if (!gate_done) begin
                        gate_cnt <= gate_cnt - 1'b1;
                    end
                end
                COMPARE: begin
                    resp_bit <= (cnt_a > cnt_b);
                    resp_err <= sat_a | sat_b;
                end
                default: begin
                end
            endcase
        end
    end

    puf_edge_counter #(
        .CNT_W(CNT_W)
    ) u_counter_a (
        .clk       (ICE_CLK),
        .rst_n     (ICE_RST_N),
        .osc       (sel_a),
        .clear     (clear_cnt),
        .enable    (count_en),
        .count     (cnt_a),
        .saturated (sat_a)
    );

    puf_edge_counter #(
        .CNT_W(CNT_W)
    ) u_counter_b (
        .clk       (ICE_CLK),
        .rst_n     (ICE_RST_N),
        .osc       (sel_b),
        .clear     (clear_cnt),
        .enable    (count_en),
        .count     (cnt_b),
        .saturated (sat_b)
    );

endmodule

// File: tb/tb_puf_reader.sv
// ----------------------------------------------------------------------------
// tb_puf_reader
// Directed bench for puf_reader. A 16-bit instance covers normal
// measurements, swapped challenge, invalid challenge, busy-start rejection and
// mid-measurement reset; an 8-bit instance covers counter saturation.
// Clock period 10 ns. Oscillators: osc[0] period 4 clk, osc[3] period 8 clk,
// osc[5] period 10 clk, all others held low.
// ----------------------------------------------------------------------------
module tb_puf_reader;

    localparam int N_OSC = 16;
    localparam int GATE  = 4096;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_OSC-1:0]  osc_in;
    logic              osc0 = 1'b0;
    logic              osc3 = 1'b0;
    logic              osc5 = 1'b0;

    logic              start;
    logic [3:0]        chal_a;
    logic [3:0]        chal_b;
    logic              busy;
    logic              resp_valid;
    logic              resp_bit;
    logic              resp_err;
    logic [15:0]       cnt_a;
    logic [15:0]       cnt_b;

    logic              start8;
    logic [3:0]        chal_a8;
    logic [3:0]        chal_b8;
    logic              busy8;
    logic              resp_valid8;
    logic              resp_bit8;
    logic              resp_err8;
    logic [7:0]        cnt_a8;
    logic [7:0]        cnt_b8;

    int                err_count   = 0;
    int                check_count = 0;
    int                valid_count = 0;
    int                pulses_before;

    always #5 clk = ~clk;

    // Oscillators are offset by 2 ns so their edges never coincide with clk.
    initial begin #2; forever #20 osc0 = ~osc0; end
    initial begin #2; forever #40 osc3 = ~osc3; end
    initial begin #2; forever #50 osc5 = ~osc5; end

    assign osc_in = {10'b0, osc5, 1'b0, osc3, 2'b0, osc0};

    puf_reader #(
        .N_OSC(N_OSC), .CNT_W(16), .GATE_CYCLES(GATE)
    ) dut (
        .ICE_CLK(clk), .ICE_RST_N(rst_n), .osc_in(osc_in), .start(start),
        .chal_a(chal_a), .chal_b(chal_b), .busy(busy), .resp_valid(resp_valid),
        .resp_bit(resp_bit), .resp_err(resp_err), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    puf_reader #(
        .N_OSC(N_OSC), .CNT_W(8), .GATE_CYCLES(GATE)
    ) dut8 (
        .ICE_CLK(clk), .ICE_RST_N(rst_n), .osc_in(osc_in), .start(start8),
        .chal_a(chal_a8), .chal_b(chal_b8), .busy(busy8), .resp_valid(resp_valid8),
        .resp_bit(resp_bit8), .resp_err(resp_err8), .cnt_a(cnt_a8), .cnt_b(cnt_b8)
    );

    // Count result strobes of the 16-bit instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (resp_valid) begin
            valid_count <= valid_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input bit use8, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        if (use8) begin
            chal_a8 = a; chal_b8 = b; start8 = 1'b1;
        end else begin
            chal_a  = a; chal_b  = b; start  = 1'b1;
        end
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; returns on the negedge where it is high.
    task automatic waitDone(input bit use8);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            seen = use8 ? resp_valid8 : resp_valid;
        end
        checkOutput("done_seen", 32'(seen), 1);
    endtask

    task automatic checkCounts(input string tag, input int lo_a, input int hi_a,
                               input int lo_b, input int hi_b);
        checkOutput({tag, "_cnt_a_range"}, 32'(cnt_a >= 16'(lo_a) && cnt_a <= 16'(hi_a)), 1);
        checkOutput({tag, "_cnt_b_range"}, 32'(cnt_b >= 16'(lo_b) && cnt_b <= 16'(hi_b)), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; chal_a = '0; chal_b = '0;
        start8 = 1'b0; chal_a8 = '0; chal_b8 = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy",       32'(busy), 0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_bit",   32'(resp_bit), 0);
        checkOutput("rst_resp_err",   32'(resp_err), 0);
        checkOutput("rst_cnt_a",      32'(cnt_a), 0);
        checkOutput("rst_cnt_b",      32'(cnt_b), 0);
        rst_n = 1'b1;

        $display("[TB] normal measurement chal 3/5");
        applyStimulus(0, 4'd3, 4'd5);
        checkOutput("a_busy", 32'(busy), 1);
        waitDone(0);
        checkCounts("a", 511, 513, 408, 410);
        checkOutput("a_resp_bit", 32'(resp_bit), 1);
        checkOutput("a_resp_err", 32'(resp_err), 0);
        checkOutput("a_busy_done", 32'(busy), 0);

        $display("[TB] swapped challenge 5/3, started the cycle after DONE");
        applyStimulus(0, 4'd5, 4'd3);
        checkOutput("b_busy", 32'(busy), 1);
        waitDone(0);
        checkCounts("b", 408, 410, 511, 513);
        checkOutput("b_resp_bit", 32'(resp_bit), 0);
        checkOutput("b_resp_err", 32'(resp_err), 0);
        @(negedge clk);
        checkOutput("b_valid_drop", 32'(resp_valid), 0);
        chal_a = 4'd0; chal_b = 4'd1;
        repeat (5) @(negedge clk);
        checkCounts("b_hold", 408, 410, 511, 513);

        $display("[TB] invalid challenge 7/7");
        applyStimulus(0, 4'd7, 4'd7);
        checkOutput("c_resp_valid", 32'(resp_valid), 1);
        checkOutput("c_resp_err",   32'(resp_err), 1);
        checkOutput("c_resp_bit",   32'(resp_bit), 0);
        checkOutput("c_cnt_a",      32'(cnt_a), 0);
        checkOutput("c_cnt_b",      32'(cnt_b), 0);
        @(negedge clk);
        checkOutput("c_valid_drop", 32'(resp_valid), 0);

        $display("[TB] saturation on 8-bit instance");
        applyStimulus(1, 4'd0, 4'd2);
        waitDone(1);
        checkOutput("d_cnt_a8",    32'(cnt_a8), 255);
        checkOutput("d_cnt_b8",    32'(cnt_b8), 0);
        checkOutput("d_resp_err8", 32'(resp_err8), 1);
        checkOutput("d_resp_bit8", 32'(resp_bit8), 1);

        $display("[TB] start while busy is ignored");
        pulses_before = valid_count;
        applyStimulus(0, 4'd3, 4'd5);
        repeat (10) @(negedge clk);
        applyStimulus(0, 4'd5, 4'd3);
        waitDone(0);
        checkCounts("e", 511, 513, 408, 410);
        checkOutput("e_resp_bit", 32'(resp_bit), 1);
        repeat (20) @(negedge clk);
        checkOutput("e_one_pulse", 32'(valid_count - pulses_before), 1);
        checkOutput("e_idle", 32'(busy), 0);

        $display("[TB] reset at gate cycle 2000");
        applyStimulus(0, 4'd3, 4'd5);
        repeat (2004) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("f_busy",       32'(busy), 0);
        checkOutput("f_resp_valid", 32'(resp_valid), 0);
        checkOutput("f_resp_bit",   32'(resp_bit), 0);
        checkOutput("f_resp_err",   32'(resp_err), 0);
        checkOutput("f_cnt_a",      32'(cnt_a), 0);
        checkOutput("f_cnt_b",      32'(cnt_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses_before = valid_count;
        repeat (4200) @(negedge clk);
        checkOutput("f_no_valid", 32'(valid_count - pulses_before), 0);
        checkOutput("f_idle",     32'(busy), 0);
        applyStimulus(0, 4'd3, 4'd5);
        checkOutput("f_restart_busy", 32'(busy), 1);
        waitDone(0);
        checkCounts("f", 511, 513, 408, 410);
        checkOutput("f_resp_bit", 32'(resp_bit), 1);
        checkOutput("f_resp_err", 32'(resp_err), 0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
